id_operand_collect: RTL and testbench
=====================================

// Module: id_operand_collect
// PURPOSE
//  Parametrised ID-stage operand collector: one pipeline slot between IF and EXE.
//  Resolves NSRC source operands per instruction from the register file or from
//  NFWD forwarding sources (EXE, MEM, WB, ...), stalls on not-yet-ready producers
//  (loads, multi-cycle ops), and supports flush. Also counts stall cycles (perf).
//  Decoding stays in the decoder; this block only moves, forwards and stalls.
// PARAMETERS
//  XLEN       32  operand/data width
//  RADDR_W    5   register address width; address 0 is hard-wired zero
//  NSRC       2   source operands per instruction (= regfile read ports)
//  NFWD       3   forwarding sources; index 0 = youngest (EXE), highest priority
//  PAYLOAD_W  64  opaque payload carried through (pc, inst, decoded ctrl)
//  CNT_W      32  stall-counter width
// PORTS
//  clk          in   1                  clock
//  reset        in   1                  async active-high reset
//  in_valid     in   1                  upstream slot valid
//  in_allow_in  out  1                  this stage accepts a new slot
//  in_payload   in   PAYLOAD_W          payload to carry
//  in_src_addr  in   NSRC*RADDR_W       source register numbers, src i at [i*RADDR_W+:RADDR_W]
//  in_src_used  in   NSRC               src i is actually read by the instruction
//  flush        in   1                  kill the held slot (branch/exception redirect)
//  rf_raddr     out  NSRC*RADDR_W       regfile read addresses (from held slot)
//  rf_rdata     in   NSRC*XLEN          regfile read data (combinational read)
//  fwd_we       in   NFWD               producer j will write a GPR
//  fwd_waddr    in   NFWD*RADDR_W       producer j destination
//  fwd_wdata    in   NFWD*XLEN          producer j result (valid only when fwd_ok[j])
//  fwd_ok       in   NFWD               producer j result available this cycle
//  out_valid    out  1                  slot valid and all operands resolved
//  out_allow_in in   1                  downstream (EXE) accepts
//  out_payload  out  PAYLOAD_W          held payload
//  out_src_data out  NSRC*XLEN          resolved operands
//  stall_cnt    out  CNT_W              saturating count of hazard-stall cycles
// BEHAVIOUR
//  - Reset (async, active-high): valid<=0, held payload/addr/used <=0, stall_cnt<=0.
//    Outputs after reset: out_valid=0, in_allow_in=1, out_src_data=0 (addr 0).
//  - Slot: valid reg + held {payload, src_addr, src_used}, loaded when
//    in_valid & in_allow_in. in_allow_in = ~valid | (ready_go & out_allow_in).
//  - Per src i: match[j] = used[i] & fwd_we[j] & (fwd_waddr[j]==addr[i]) & addr[i]!=0.
//    Winner = lowest j with match. Operand = addr 0 ? 0 : winner ? fwd_wdata[j] : rf_rdata[i].
//    Not-ready if winner exists and ~fwd_ok[winner]; older matching sources never
//    override a younger not-ready one. Unused src drives the rf value (don't-care).
//  - ready_go = AND over i of ~notready[i]; out_valid = valid & ready_go & ~flush.
//  - Zero added latency: slot loaded at edge N is presented at EXE in cycle N if ready.
//  - Operands are recomputed every cycle while held (no operand latching); a
//    producer that advances (EXE->MEM) is still found at its new index.
//  - flush: valid<=0 at next edge; takes priority over a same-cycle load
//    (incoming slot is dropped; upstream is flushed by the same signal).
//    in_allow_in stays as defined; out_valid forced 0 in the flush cycle.
//  - Simultaneous transfer out and in: new slot overwrites held slot, valid stays 1.
//  - stall_cnt += 1 on each cycle with valid & ~ready_go & ~flush; saturates at
//    all-ones (no wrap). Downstream back-pressure (out_allow_in=0) is not counted.
//  - Widths: all compares at RADDR_W; no arithmetic on data.
// STRUCTURE
//  - Shared package: RADDR_W/XLEN defaults, ZERO_REG constant, fwd-entry field
//    offsets used by EXE/MEM/WB when building their fwd buses.
//  - One sub-module: fwd_select (per source operand: priority match over NFWD,
//    outputs data + notready); instantiated NSRC times via generate.
//  - Slot register and stall counter stay in the top module.
// TESTING
//  - No hazard: load addr{3,4}, rf={0x11,0x22}, no fwd_we -> out_valid same cycle, data {0x11,0x22}.
//  - Priority: fwd0 and fwd2 both write r5 (0xAA, 0xCC), ok=1 -> operand 0xAA.
//  - Load-use: fwd0 writes r7, ok=0 for 2 cycles then 1 with 0x55 -> out_valid 0,0,1;
//    in_allow_in 0 during stall; stall_cnt=2.
//  - r0: src addr 0, fwd0 writes r0 ok=0 -> no stall, operand 0.
//  - Flush during stall with in_valid=1 -> next cycle valid=0, incoming slot dropped,
//    stall_cnt unchanged for flush cycle.
//  - Async reset asserted mid-stall between edges -> out_valid=0, stall_cnt=0 immediately.

Source files
------------

// File: rtl/id_operand_collect_pkg.sv
// Shared definitions for the ID-stage operand collector.
// Default widths, the hard-wired zero register number, and the bit layout of
// one forwarding-bus entry. EXE/MEM/WB use that layout when they pack
// {ok, we, waddr, wdata} into their forwarding outputs.
package id_operand_collect_pkg;
  localparam int XLEN_DEF      = 32;
  localparam int RADDR_W_DEF   = 5;
  localparam int NSRC_DEF      = 2;
  localparam int NFWD_DEF      = 3;
  localparam int PAYLOAD_W_DEF = 64;
  localparam int CNT_W_DEF     = 32;

  // Register 0 always reads as zero and is never a forwarding target.
  localparam int ZERO_REG = 0;

  // Layout of one forwarding entry, LSB first: wdata, waddr, we, ok.
  localparam int FWD_DATA_LSB = 0;
  localparam int FWD_ADDR_LSB = FWD_DATA_LSB + XLEN_DEF;
  localparam int FWD_WE_BIT   = FWD_ADDR_LSB + RADDR_W_DEF;
  localparam int FWD_OK_BIT   = FWD_WE_BIT + 1;
  localparam int FWD_ENTRY_W  = FWD_OK_BIT + 1;
endpackage

// File: rtl/id_operand_collect_if.sv
// Bus bundle for id_operand_collect: upstream slot, downstream slot,
// regfile read ports, forwarding inputs and the stall counter.
// Modports:
//   slave  - the operand collector itself
//   master - the surrounding pipeline (or a testbench)
// Packed arrays keep the flat layout: element i sits at [i*W +: W].
interface id_operand_collect_if
  import id_operand_collect_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int RADDR_W   = RADDR_W_DEF,
  parameter int NSRC      = NSRC_DEF,
  parameter int NFWD      = NFWD_DEF,
  parameter int PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
);
  logic                               in_valid;
  logic                               in_allow_in;
  logic [PAYLOAD_W-1:0]               in_payload;
  logic [NSRC-1:0][RADDR_W-1:0]       in_src_addr;
  logic [NSRC-1:0]                    in_src_used;
  logic                               flush;
  logic [NSRC-1:0][RADDR_W-1:0]       rf_raddr;
  logic [NSRC-1:0][XLEN-1:0]          rf_rdata;
  logic [NFWD-1:0]                    fwd_we;
  logic [NFWD-1:0][RADDR_W-1:0]       fwd_waddr;
  logic [NFWD-1:0][XLEN-1:0]          fwd_wdata;
  logic [NFWD-1:0]                    fwd_ok;
  logic                               out_valid;
  logic                               out_allow_in;
  logic [PAYLOAD_W-1:0]               out_payload;
  logic [NSRC-1:0][XLEN-1:0]          out_src_data;
  logic [CNT_W-1:0]                   stall_cnt;

  modport slave (
    input  in_valid, in_payload, in_src_addr, in_src_used, flush,
           rf_rdata, fwd_we, fwd_waddr, fwd_wdata, fwd_ok, out_allow_in,
    output in_allow_in, rf_raddr, out_valid, out_payload, out_src_data,
           stall_cnt
  );

  modport master (
    output in_valid, in_payload, in_src_addr, in_src_used, flush,
           rf_rdata, fwd_we, fwd_waddr, fwd_wdata, fwd_ok, out_allow_in,
    input  in_allow_in, rf_raddr, out_valid, out_payload, out_src_data,
           stall_cnt
  );
endinterface

// File: rtl/id_operand_collect_fwd_select.sv
// Forwarding selector for one source operand.
// Picks the youngest matching producer (lowest index) among NFWD forwarding
// sources, falling back to the regfile value. Register 0 always yields zero.
// Ports:
//   used, addr   - held source descriptor
//   rf_data      - regfile read data for this source
//   fwd_*        - forwarding buses, index 0 = youngest
//   data         - resolved operand
//   notready     - youngest matching producer has no result yet
module id_operand_collect_fwd_select
  import id_operand_collect_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int NFWD    = NFWD_DEF
) (
  input  logic                         used,
  input  logic [RADDR_W-1:0]           addr,
  input  logic [XLEN-1:0]              rf_data,
  input  logic [NFWD-1:0]              fwd_we,
  input  logic [NFWD-1:0][RADDR_W-1:0] fwd_waddr,
  input  logic [NFWD-1:0][XLEN-1:0]    fwd_wdata,
  input  logic [NFWD-1:0]              fwd_ok,
  output logic [XLEN-1:0]              data,
  output logic                         notready
);
  logic            is_zero;
  logic            hit;
  logic            sel_ok;
  logic [XLEN-1:0] sel_data;

  assign is_zero = (addr == RADDR_W'(ZERO_REG));

  // Walk oldest to youngest so the youngest match is the last one written;
  // an older ready producer can never mask a younger pending one.
  always_comb begin
    hit      = 1'b0;
    sel_ok   = 1'b1;
    sel_data = rf_data;
    for (int j = NFWD - 1; j >= 0; j--) begin
      if (used && !is_zero && fwd_we[j] && (fwd_waddr[j] == addr)) begin
        hit      = 1'b1;
        sel_ok   = fwd_ok[j];
        sel_data = fwd_wdata[j];
      end
    end
  end

  assign data     = is_zero ? '0 : sel_data;
  assign notready = hit & ~sel_ok;
endmodule

// File: rtl/id_operand_collect.sv
// ID-stage operand collector: a single pipeline slot between IF and EXE.
// Holds {payload, src addresses, src used}, reads operands from the regfile or
// the forwarding network every cycle, stalls while a matching producer has no
// result yet, and counts those stall cycles (saturating).
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   bus        - slave side of id_operand_collect_if (upstream/downstream
//                handshakes, regfile read ports, forwarding, stall_cnt)
module id_operand_collect
  import id_operand_collect_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int RADDR_W   = RADDR_W_DEF,
  parameter int NSRC      = NSRC_DEF,
  parameter int NFWD      = NFWD_DEF,
  parameter int PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input logic                clk,
  input logic                reset,
  id_operand_collect_if.slave bus
);
  logic                         valid;
  logic [PAYLOAD_W-1:0]         pay_q;
  logic [NSRC-1:0][RADDR_W-1:0] addr_q;
  logic [NSRC-1:0]              used_q;
  logic [CNT_W-1:0]             cnt_q;

  logic [NSRC-1:0]              notready;
  logic [NSRC-1:0][XLEN-1:0]    src_data;
  logic [NSRC-1:0][XLEN-1:0]    rf_data;
  logic                         ready_go;
  logic                         allow_in;
  logic                         load;
  logic                         xfer_out;
  logic                         stall;

  assign rf_data = bus.rf_rdata;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    id_operand_collect_fwd_select #(
      .XLEN    (XLEN),
      .RADDR_W (RADDR_W),
      .NFWD    (NFWD)
    ) u_sel (
      .used      (used_q[i]),
      .addr      (addr_q[i]),
      .rf_data   (rf_data[i]),
      .fwd_we    (bus.fwd_we),
      .fwd_waddr (bus.fwd_waddr),
      .fwd_wdata (bus.fwd_wdata),
      .fwd_ok    (bus.fwd_ok),
      .data      (src_data[i]),
      .notready  (notready[i])
    );
  end

  assign ready_go = ~|notready;
  assign allow_in = ~valid | (ready_go & bus.out_allow_in);
  assign load     = bus.in_valid & allow_in;
  assign xfer_out = valid & ready_go & bus.out_allow_in & ~bus.flush;
  // Back-pressure from EXE is not a hazard and is deliberately not counted.
  assign stall    = valid & ~ready_go & ~bus.flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid  <= 1'b0;
      pay_q  <= '0;
      addr_q <= '0;
      used_q <= '0;
      cnt_q  <= '0;
    end else begin
      // Flush wins over a same-cycle load; upstream sees the same flush.
      if (bus.flush)    valid <= 1'b0;
      else if (load)    valid <= 1'b1;
      else if (xfer_out) valid <= 1'b0;

      if (load && !bus.flush) begin
        pay_q  <= bus.in_payload;
        addr_q <= bus.in_src_addr;
        used_q <= bus.in_src_used;
      end

      if (stall && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.in_allow_in  = allow_in;
  assign bus.rf_raddr     = addr_q;
  assign bus.out_valid    = valid & ready_go & ~bus.flush;
  assign bus.out_payload  = pay_q;
  assign bus.out_src_data = src_data;
  assign bus.stall_cnt    = cnt_q;
endmodule

// File: tb/tb_id_operand_collect.sv
module tb_id_operand_collect;
  localparam int CW = 3;  // narrow counter so saturation is reachable

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  id_operand_collect_if #(.CNT_W(CW)) bus ();

  id_operand_collect #(.CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  a0, a1;
    logic [1:0]  used;
    logic [31:0] rf0, rf1;
    logic [2:0]  we, ok;
    logic [4:0]  wa0, wa1, wa2;
    logic [31:0] wd0, wd1, wd2;
    logic        ev;
    logic [31:0] e0, e1;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_fwd0(input logic we, input logic [4:0] wa, input logic ok, input logic [31:0] wd);
    bus.fwd_we    = {2'b00, we};
    bus.fwd_waddr = {5'd0, 5'd0, wa};
    bus.fwd_ok    = {2'b00, ok};
    bus.fwd_wdata = {32'd0, 32'd0, wd};
  endtask

  initial begin
    //          a0 a1  used  rf0      rf1      we      ok      wa0 wa1 wa2  wd0       wd1       wd2       ev   e0        e1
    vecs[0] = '{5'd3, 5'd4, 2'b11, 32'h11, 32'h22, 3'b000, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h11, 32'h22};
    vecs[1] = '{5'd5, 5'd6, 2'b11, 32'h1, 32'h2, 3'b101, 3'b111, 5'd5, 5'd9, 5'd5, 32'hAA, 32'hBB, 32'hCC, 1'b1, 32'hAA, 32'h2};
    vecs[2] = '{5'd5, 5'd6, 2'b11, 32'h1, 32'h2, 3'b101, 3'b111, 5'd1, 5'd0, 5'd6, 32'hAA, 32'h0, 32'hCC, 1'b1, 32'h1, 32'hCC};
    vecs[3] = '{5'd0, 5'd4, 2'b11, 32'h99, 32'h22, 3'b001, 3'b000, 5'd0, 5'd0, 5'd0, 32'h77, 32'h0, 32'h0, 1'b1, 32'h0, 32'h22};
    vecs[4] = '{5'd7, 5'd8, 2'b11, 32'h31, 32'h32, 3'b011, 3'b010, 5'd7, 5'd7, 5'd0, 32'h55, 32'h66, 32'h0, 1'b0, 32'h55, 32'h32};
    vecs[5] = '{5'd7, 5'd8, 2'b10, 32'h31, 32'h32, 3'b001, 3'b000, 5'd7, 5'd0, 5'd0, 32'h55, 32'h0, 32'h0, 1'b1, 32'h31, 32'h32};
    vecs[6] = '{5'd2, 5'd3, 2'b11, 32'h41, 32'h42, 3'b011, 3'b010, 5'd9, 5'd3, 5'd0, 32'h0, 32'hDEAD, 32'h0, 1'b1, 32'h41, 32'hDEAD};
    vecs[7] = '{5'd10, 5'd10, 2'b11, 32'h51, 32'h52, 3'b010, 3'b010, 5'd0, 5'd10, 5'd0, 32'h0, 32'h1234, 32'h0, 1'b1, 32'h1234, 32'h1234};
    vecs[8] = '{5'd5, 5'd6, 2'b11, 32'h61, 32'h62, 3'b000, 3'b000, 5'd5, 5'd0, 5'd0, 32'hEE, 32'h0, 32'h0, 1'b1, 32'h61, 32'h62};
    vecs[9] = '{5'd1, 5'd12, 2'b11, 32'h71, 32'h72, 3'b100, 3'b000, 5'd0, 5'd0, 5'd12, 32'h0, 32'h0, 32'h99, 1'b0, 32'h71, 32'h99};

    // Reset state
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_payload = '0; bus.in_src_addr = '0; bus.in_src_used = '0;
    bus.flush = 1'b0; bus.out_allow_in = 1'b1;
    bus.rf_rdata = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
    set_fwd0(1'b0, 5'd0, 1'b0, 32'd0);
    #12;
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst in_allow_in", 64'(bus.in_allow_in), 64'd1);
    chk("rst src0", 64'(bus.out_src_data[0]), 64'd0);
    chk("rst src1", 64'(bus.out_src_data[1]), 64'd0);
    chk("rst stall_cnt", 64'(bus.stall_cnt), 64'd0);
    chk("rst payload", bus.out_payload, 64'd0);
    @(negedge clk); reset = 1'b0;

    // Table: load a slot, present operand sources, check, then flush it away
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.flush = 1'b0; bus.in_valid = 1'b1; bus.out_allow_in = 1'b0;
      bus.in_src_addr = {vecs[i].a1, vecs[i].a0};
      bus.in_src_used = vecs[i].used;
      bus.in_payload = {32'hC0DE_0000, 32'(i)};
      bus.fwd_we = '0;
      @(negedge clk);
      bus.in_valid = 1'b0; bus.out_allow_in = 1'b1;
      bus.rf_rdata  = {vecs[i].rf1, vecs[i].rf0};
      bus.fwd_we    = vecs[i].we;
      bus.fwd_ok    = vecs[i].ok;
      bus.fwd_waddr = {vecs[i].wa2, vecs[i].wa1, vecs[i].wa0};
      bus.fwd_wdata = {vecs[i].wd2, vecs[i].wd1, vecs[i].wd0};
      #1;
      chk($sformatf("v%0d out_valid", i), 64'(bus.out_valid), 64'(vecs[i].ev));
      chk($sformatf("v%0d in_allow_in", i), 64'(bus.in_allow_in), 64'(vecs[i].ev));
      chk($sformatf("v%0d src0", i), 64'(bus.out_src_data[0]), 64'(vecs[i].e0));
      chk($sformatf("v%0d src1", i), 64'(bus.out_src_data[1]), 64'(vecs[i].e1));
      chk($sformatf("v%0d payload", i), bus.out_payload, {32'hC0DE_0000, 32'(i)});
      chk($sformatf("v%0d rf_raddr", i), 64'(bus.rf_raddr), 64'({vecs[i].a1, vecs[i].a0}));
      bus.flush = 1'b1;
    end
    @(negedge clk);
    bus.flush = 1'b0;
    chk("table stall_cnt", 64'(bus.stall_cnt), 64'd0);

    // Load-use stall for two cycles, then simultaneous out/in transfer
    bus.in_valid = 1'b1; bus.in_src_addr = {5'd3, 5'd7}; bus.in_src_used = 2'b11;
    bus.in_payload = 64'hA; bus.out_allow_in = 1'b1;
    bus.rf_rdata = {32'h33, 32'h70};
    set_fwd0(1'b0, 5'd0, 1'b0, 32'd0);
    @(negedge clk);
    bus.in_payload = 64'hB; bus.in_src_addr = {5'd2, 5'd1};
    set_fwd0(1'b1, 5'd7, 1'b0, 32'h55);
    #1;
    chk("lu c0 out_valid", 64'(bus.out_valid), 64'd0);
    chk("lu c0 in_allow_in", 64'(bus.in_allow_in), 64'd0);
    @(negedge clk); #1;
    chk("lu c1 out_valid", 64'(bus.out_valid), 64'd0);
    chk("lu c1 in_allow_in", 64'(bus.in_allow_in), 64'd0);
    chk("lu c1 stall_cnt", 64'(bus.stall_cnt), 64'd1);
    @(negedge clk);
    set_fwd0(1'b1, 5'd7, 1'b1, 32'h55);
    #1;
    chk("lu c2 out_valid", 64'(bus.out_valid), 64'd1);
    chk("lu c2 in_allow_in", 64'(bus.in_allow_in), 64'd1);
    chk("lu c2 src0", 64'(bus.out_src_data[0]), 64'h55);
    chk("lu c2 src1", 64'(bus.out_src_data[1]), 64'h33);
    chk("lu c2 payload", bus.out_payload, 64'hA);
    chk("lu c2 stall_cnt", 64'(bus.stall_cnt), 64'd2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    set_fwd0(1'b0, 5'd0, 1'b0, 32'd0);
    #1;
    chk("overlap out_valid", 64'(bus.out_valid), 64'd1);
    chk("overlap payload", bus.out_payload, 64'hB);
    chk("overlap rf_raddr", 64'(bus.rf_raddr), 64'({5'd2, 5'd1}));
    chk("overlap stall_cnt", 64'(bus.stall_cnt), 64'd2);

    // Flush during a stall while a new slot is waiting upstream
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_src_addr = {5'd0, 5'd7}; bus.in_payload = 64'hC;
    @(negedge clk);
    bus.in_valid = 1'b0;
    set_fwd0(1'b1, 5'd7, 1'b0, 32'h0);
    #1;
    chk("fl stall out_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_payload = 64'hD; bus.flush = 1'b1;
    #1;
    chk("fl cycle out_valid", 64'(bus.out_valid), 64'd0);
    chk("fl cycle in_allow_in", 64'(bus.in_allow_in), 64'd0);
    chk("fl cycle stall_cnt", 64'(bus.stall_cnt), 64'd3);
    @(negedge clk);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    #1;
    chk("fl after out_valid", 64'(bus.out_valid), 64'd0);
    chk("fl after in_allow_in", 64'(bus.in_allow_in), 64'd1);
    chk("fl after stall_cnt", 64'(bus.stall_cnt), 64'd3);

    // Flush beats a same-cycle load into an empty slot
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_src_addr = {5'd4, 5'd3}; bus.in_payload = 64'hE;
    bus.flush = 1'b1;
    set_fwd0(1'b0, 5'd0, 1'b0, 32'd0);
    #1;
    chk("fl load in_allow_in", 64'(bus.in_allow_in), 64'd1);
    @(negedge clk);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    #1;
    chk("fl load dropped", 64'(bus.out_valid), 64'd0);

    // Long stall: counter saturates at all-ones
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_src_addr = {5'd0, 5'd7}; bus.in_payload = 64'hF;
    @(negedge clk);
    bus.in_valid = 1'b0;
    set_fwd0(1'b1, 5'd7, 1'b0, 32'h0);
    repeat (6) @(negedge clk);
    #1;
    chk("sat stall_cnt", 64'(bus.stall_cnt), 64'd7);
    chk("sat out_valid", 64'(bus.out_valid), 64'd0);

    // Async reset between edges in the middle of the stall
    #2 reset = 1'b1;
    #1;
    chk("arst out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst stall_cnt", 64'(bus.stall_cnt), 64'd0);
    chk("arst in_allow_in", 64'(bus.in_allow_in), 64'd1);
    chk("arst src0", 64'(bus.out_src_data[0]), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    chk("post rst stall_cnt", 64'(bus.stall_cnt), 64'd0);
    chk("post rst out_valid", 64'(bus.out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
